// File: rtl/uart_tx_fifo.sv
// UART transmitter with a fractional baud accumulator, a TX FIFO and a runtime frame format.
// Frame configuration is captured at pop time. Polarity is applied live at the pad.
//   state    | meaning
//   S_IDLE   | line idle, waiting for a tick with tx_en and queued data
//   S_START  | start bit on the line
//   S_DATA   | data bit r_cnt on the line
//   S_PARITY | parity bit on the line
//   S_STOP   | stop bit r_scnt on the line
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_ACC_W = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        wr_valid_i,
  input  logic [DATA_W-1:0]           wr_data_i,
  output logic                        wr_ready_o,
  input  logic                        tx_en,
  input  logic                        parity_en,
  input  logic                        parity_odd,
  input  logic                        data_order,
  input  logic                        polarity,
  input  logic                        stop2,
  input  logic [$clog2(DATA_W+1)-1:0] data_bits,
  input  logic [BAUD_ACC_W-1:0]       bauds_lim,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

  localparam int NB_W  = $clog2(DATA_W + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [NB_W-1:0]  NB_MAX  = NB_W'(DATA_W);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t              r_state, w_state_nxt;
  logic [BAUD_ACC_W:0] r_acc;
  logic                w_tick;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic                w_push, w_pop, w_can_start;
  logic [DATA_W-1:0]   w_head;

  logic [DATA_W-1:0]   r_data;
  logic [NB_W-1:0]     w_nbits_eff, r_nbits;
  logic                r_par_en, r_par_bit, r_msb, r_stop2, w_par_calc;

  logic [NB_W-1:0]     r_cnt, w_cnt_nxt, w_idx, w_sel;
  logic                r_scnt, w_scnt_nxt;
  logic                r_line, w_line_nxt, w_bit, w_done;

  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = w_done;
  assign tx_o         = r_line ^ polarity;
  assign fifo_level_o = r_level;
  assign wr_ready_o   = (r_level < LVL_MAX);

  // Carry out of the accumulator is registered, so a tick is a clean one-cycle pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              r_acc <= '0;
    else if (tx_en || busy_o) r_acc <= {1'b0, r_acc[BAUD_ACC_W-1:0]} + {1'b0, bauds_lim};
    else                      r_acc <= '0;
  end
  assign w_tick = r_acc[BAUD_ACC_W];

  assign w_push      = wr_valid_i && wr_ready_o;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_can_start = tx_en && (r_level != '0);

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign w_nbits_eff = (data_bits == '0 || data_bits > NB_MAX) ? NB_MAX : data_bits;

  // Parity is computed from the head word as it is popped, over the bits that will be sent.
  always_comb begin
    w_par_calc = parity_odd;
    for (int i = 0; i < DATA_W; i++) begin
      if (NB_W'(i) < w_nbits_eff) w_par_calc = w_par_calc ^ w_head[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data    <= '0;
      r_nbits   <= NB_MAX;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_msb     <= 1'b0;
      r_stop2   <= 1'b0;
    end else if (w_pop) begin
      r_data    <= w_head;
      r_nbits   <= w_nbits_eff;
      r_par_en  <= parity_en;
      r_par_bit <= w_par_calc;
      r_msb     <= data_order;
      r_stop2   <= stop2;
    end
  end

  assign w_idx = (r_state == S_START) ? '0 : r_cnt + NB_W'(1);
  assign w_sel = r_msb ? (r_nbits - NB_W'(1) - w_idx) : w_idx;

  always_comb begin
    w_bit = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (NB_W'(i) == w_sel) w_bit = r_data[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_line  <= 1'b1;
      r_cnt   <= '0;
      r_scnt  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_line  <= w_line_nxt;
      r_cnt   <= w_cnt_nxt;
      r_scnt  <= w_scnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = r_line;
    w_cnt_nxt   = r_cnt;
    w_scnt_nxt  = r_scnt;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_can_start) begin
            w_pop       = 1'b1;
            w_line_nxt  = 1'b0;
            w_state_nxt = S_START;
          end
        end
        S_START: begin
          w_line_nxt  = w_bit;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end
        S_DATA: begin
          if (r_cnt == r_nbits - NB_W'(1)) begin
            if (r_par_en) begin
              w_line_nxt  = r_par_bit;
              w_state_nxt = S_PARITY;
            end else begin
              w_line_nxt  = 1'b1;
              w_scnt_nxt  = 1'b0;
              w_state_nxt = S_STOP;
            end
          end else begin
            w_line_nxt = w_bit;
            w_cnt_nxt  = r_cnt + NB_W'(1);
          end
        end
        S_PARITY: begin
          w_line_nxt  = 1'b1;
          w_scnt_nxt  = 1'b0;
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          if (r_stop2 && !r_scnt) begin
            w_scnt_nxt = 1'b1;
          end else begin
            w_done = 1'b1;
            // Chain straight into the next start bit so queued frames leave no idle gap.
            if (w_can_start) begin
              w_pop       = 1'b1;
              w_line_nxt  = 1'b0;
              w_state_nxt = S_START;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: writes push expected frames, a line monitor pops and checks them.
module tb_uart_tx_fifo;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int BAUD_ACC_W = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wr_valid_i = 1'b0;
  logic [7:0]  wr_data_i = '0;
  logic        wr_ready_o;
  logic        tx_en = 1'b0, parity_en = 1'b0, parity_odd = 1'b0;
  logic        data_order = 1'b0, polarity = 1'b0, stop2 = 1'b0;
  logic [3:0]  data_bits = 4'd8;
  logic [15:0] bauds_lim = 16'h4000;
  logic        tx_o, busy_o, done_o;
  logic [2:0]  fifo_level_o;

  uart_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .BAUD_ACC_W(BAUD_ACC_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o), .tx_en(tx_en), .parity_en(parity_en), .parity_odd(parity_odd),
    .data_order(data_order), .polarity(polarity), .stop2(stop2), .data_bits(data_bits),
    .bauds_lim(bauds_lim), .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o),
    .fifo_level_o(fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] bits;
    int          len;
    int          per;
    bit          b2b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  bit         mon_en = 1'b1;
  bit         mon_active = 1'b0;
  exp_t       cur;
  int         m_idx, gap, frame_no;
  logic       m_line, exp_bit;
  bit         bit_bad, busy_bad, done_bad, done_seen, last;
  logic [7:0] seen;

  // Reference frame from the current bench configuration: start, data, optional parity, stops.
  function automatic exp_t make_frame(input logic [7:0] d, input bit b2b);
    exp_t e;
    int   n, k;
    logic par, b;
    n = (data_bits == 4'd0 || data_bits > 4'd8) ? 8 : int'(data_bits);
    e.bits = '0;
    k = 1;
    par = 1'b0;
    for (int i = 0; i < n; i++) begin
      b = data_order ? d[n-1-i] : d[i];
      e.bits[k] = b;
      par = par ^ b;
      k++;
    end
    if (parity_en) begin
      e.bits[k] = par ^ parity_odd;
      k++;
    end
    e.bits[k] = 1'b1;
    k++;
    if (stop2) begin
      e.bits[k] = 1'b1;
      k++;
    end
    e.len = k;
    e.per = 65536 / int'(bauds_lim);
    e.b2b = b2b;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic write_word(input logic [7:0] d, input bit push);
    int t;
    t = 0;
    @(negedge clk_i);
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    while (!wr_ready_o && t < 2000) begin
      @(negedge clk_i);
      t++;
    end
    if (!wr_ready_o) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: wr_ready_o stayed %0b, required 1", wr_ready_o);
      wr_valid_i = 1'b0;
    end else begin
      if (push) exp_q.push_back(make_frame(d, 1'b0));
      @(negedge clk_i);
      wr_valid_i = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mon_active || busy_o || fifo_level_o != 0) && t < 4000) begin
      @(negedge clk_i);
      t++;
    end
    checks++;
    if (t >= 4000) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0b level=%0d pending=%0d, required idle/empty",
               busy_o, fifo_level_o, exp_q.size());
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_ni) begin
        mon_active = 1'b0;
        gap = 0;
      end else begin
        m_line = tx_o ^ polarity;
        if (!mon_active) begin
          if (mon_en && m_line == 1'b0) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame: start bit seen, got frame, required none queued");
            end else begin
              cur = exp_q.pop_front();
              mon_active = 1'b1;
              m_idx = 0;
              bit_bad = 0; busy_bad = 0; done_bad = 0; done_seen = 0;
              seen = '0;
              if (cur.b2b) begin
                checks++;
                if (gap != 0) begin
                  errors++;
                  $display("FAIL b2b_gap frame%0d: got %0d idle cycles, required 0", frame_no, gap);
                end
              end
            end
          end else begin
            gap++;
          end
        end
        if (mon_active) begin
          exp_bit = cur.bits[m_idx / cur.per];
          seen = {seen[6:0], m_line};
          if (m_line !== exp_bit) bit_bad = 1;
          if (busy_o !== 1'b1) busy_bad = 1;
          last = (m_idx == cur.len * cur.per - 1);
          if (done_o === 1'b1) begin
            if (last) done_seen = 1;
            else      done_bad = 1;
          end
          if (m_idx % cur.per == cur.per - 1) begin
            checks++;
            if (bit_bad) begin
              errors++;
              $display("FAIL frame%0d bit%0d: line samples %b, required %0d cycles of %0b",
                       frame_no, m_idx / cur.per, seen, cur.per, exp_bit);
            end
            bit_bad = 0;
            seen = '0;
          end
          m_idx++;
          if (last) begin
            checks++;
            if (!done_seen || done_bad) begin
              errors++;
              $display("FAIL frame%0d done_o: got last=%0b extra=%0b, required last=1 extra=0",
                       frame_no, done_seen, done_bad);
            end
            checks++;
            if (busy_bad) begin
              errors++;
              $display("FAIL frame%0d busy_o: got low inside frame, required high", frame_no);
            end
            frame_no++;
            mon_active = 1'b0;
            gap = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int   ref_level, t, nw;
    logic frozen;
    bit   stable;

    repeat (3) @(negedge clk_i);
    chk("reset_tx", tx_o, 1);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_level", fifo_level_o, 0);
    chk("reset_ready", wr_ready_o, 1);
    rst_ni = 1'b1;

    tx_en = 1'b1;
    write_word(8'hA5, 1);
    wait_idle();
    chk("busy_after_stop", busy_o, 0);
    chk("idle_line", tx_o, 1);

    parity_en = 1'b1;
    write_word(8'hA5, 1);
    wait_idle();
    parity_odd = 1'b1;
    write_word(8'hA5, 1);
    wait_idle();
    stop2 = 1'b1;
    write_word(8'hA5, 1);
    wait_idle();
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;

    data_bits = 4'd7; data_order = 1'b1;
    write_word(8'h41, 1);
    wait_idle();
    data_bits = 4'd8; data_order = 1'b0;

    tx_en = 1'b0;
    ref_level = 0;
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      wr_valid_i = 1'b1;
      wr_data_i  = 8'($urandom);
      if (ref_level < FIFO_DEPTH) begin
        exp_q.push_back(make_frame(wr_data_i, ref_level != 0));
        ref_level++;
      end
      @(negedge clk_i);
    end
    wr_valid_i = 1'b0;
    chk("burst_level", fifo_level_o, 4);
    chk("burst_ready", wr_ready_o, 0);
    tx_en = 1'b1;
    wait_idle();

    polarity = 1'b1;
    @(negedge clk_i);
    chk("idle_pol1", tx_o, 0);
    write_word(8'h3C, 1);
    wait_idle();

    mon_en = 1'b0;
    tx_en = 1'b0;
    write_word(8'hC3, 0);
    write_word(8'h5A, 0);
    tx_en = 1'b1;
    t = 0;
    while (!busy_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    chk("freeze_start", busy_o, 1);
    repeat (13) @(negedge clk_i);
    bauds_lim = 16'h0000;
    repeat (2) @(negedge clk_i);
    frozen = tx_o;
    chk("freeze_value", frozen, 1);
    stable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (tx_o !== frozen || busy_o !== 1'b1) stable = 1'b0;
    end
    chk("freeze_stable", stable, 1);
    chk("freeze_level", fifo_level_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midreset_tx", tx_o, 0);
    chk("midreset_busy", busy_o, 0);
    chk("midreset_level", fifo_level_o, 0);
    chk("midreset_ready", wr_ready_o, 1);
    exp_q.delete();
    @(negedge clk_i);
    polarity = 1'b0;
    bauds_lim = 16'h4000;
    @(negedge clk_i);
    rst_ni = 1'b1;
    mon_en = 1'b1;
    @(negedge clk_i);

    for (int it = 0; it < 30; it++) begin
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      data_order = 1'($urandom_range(0, 1));
      stop2      = 1'($urandom_range(0, 1));
      polarity   = 1'($urandom_range(0, 1));
      data_bits  = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0:       bauds_lim = 16'h8000;
        1:       bauds_lim = 16'h4000;
        default: bauds_lim = 16'h2000;
      endcase
      nw = $urandom_range(1, 5);
      for (int j = 0; j < nw; j++) write_word(8'($urandom), 1);
      wait_idle();
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter: fractional phase-accumulator baud generator, FIFO-buffered write interface, runtime-configurable frame format. Successor to the baud-tick-only UART core. Accepts words over a valid/ready handshake and serialises them on tx_o as start/data/parity/stop frames. Sits between the register interface (writes, config) and the chip TX pad.

Parameters:
DATA_W, 8, maximum data bits per frame (legal 5..15)
FIFO_DEPTH, 4, TX FIFO entries (power of 2, >=2)
BAUD_ACC_W, 16, baud accumulator width; tick rate = f_clk * bauds_lim / 2^BAUD_ACC_W

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
wr_valid_i  in  1  write request
wr_data_i  in  DATA_W  write word
wr_ready_o  out  1  FIFO not full
tx_en  in  1  enable starting new frames
parity_en  in  1  append parity bit
parity_odd  in  1  1 = odd parity, 0 = even
data_order  in  1  0 = LSB first, 1 = MSB first
polarity  in  1  1 = invert line (idle low)
stop2  in  1  0 = 1 stop bit, 1 = 2 stop bits
data_bits  in  $clog2(DATA_W+1)  data bits per frame
bauds_lim  in  BAUD_ACC_W  accumulator increment
tx_o  out  1  serial line
busy_o  out  1  frame in progress (state != IDLE)
done_o  out  1  one-cycle pulse at end of each frame
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_ni=0): accumulator 0, FIFO empty, state IDLE, line register 1 (tx_o = ~polarity), busy_o=0, done_o=0, fifo_level_o=0, wr_ready_o=1. Reset mid-frame aborts immediately; queued data lost.
- Baud gen: acc[BAUD_ACC_W:0] <= {0, acc[BAUD_ACC_W-1:0]} + {0, bauds_lim}; tick = acc[BAUD_ACC_W] (registered carry, 1-cycle pulse). Runs while tx_en=1 or busy_o=1; otherwise held at 0. bauds_lim=0: no ticks, FSM frozen in current state, tx_o held.
- FIFO: push when wr_valid_i && wr_ready_o; wr_ready_o = level < FIFO_DEPTH. Pop only by FSM on frame start. Push and pop in the same cycle: level unchanged. Writes accepted regardless of tx_en. Pointers wrap modulo FIFO_DEPTH.
- data_bits: legal 1..DATA_W; 0 or >DATA_W treated as DATA_W.
- Frame config (data_bits, parity_en, parity_odd, data_order, stop2) latched at pop; mid-frame changes affect only later frames. polarity is live: tx_o = line_q XOR polarity; change only while idle.
- FSM (all transitions on tick only):
  IDLE: tick && tx_en && level>0 -> pop, load shifter, line<=0, START.
  START: tick -> line<=first data bit, cnt<=0, DATA.
  DATA: tick -> cnt==N-1 ? (parity_en ? line<=parity, PARITY : line<=1, STOP) : next bit, cnt++.
  PARITY: tick -> line<=1, scnt<=0, STOP.
  STOP: tick && scnt<stop_bits-1 -> scnt++; final tick -> done_o=1 for that cycle; if tx_en && level>0: pop, line<=0, START (back-to-back, no idle gap); else IDLE.
- Bit selection: LSB first sends wr_data[0..N-1]; MSB first sends wr_data[N-1..0]; bits >= N ignored.
- Parity over the N transmitted bits: even = XOR, odd = ~XOR.
- Every bit lasts exactly one tick interval; line changes the cycle after the tick.
- tx_en deasserted mid-frame: current frame completes; no further pop.

Test Plan:
- BAUD_ACC_W=16, bauds_lim=16'h4000, 8N1 LSB-first, write 0xA5 -> tx_o = 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; one done_o pulse; busy_o low after stop.
- Same, parity_en=1: even -> parity bit 0; parity_odd=1 -> 1; stop2=1 -> stop high for 8 cycles.
- data_bits=7, MSB first, write 0x41 -> data bits 1,0,0,0,0,0,1 then stop.
- tx_en=0, write 5 words with wr_valid_i held -> 4 accepted, fifo_level_o=4, wr_ready_o=0; set tx_en=1 -> 4 back-to-back frames, no idle between stop and next start.
- polarity=1 -> idle tx_o=0, start bit 1; bauds_lim=0 mid-frame -> tx_o frozen, busy_o=1.
- Assert rst_ni low mid-DATA -> tx_o = ~polarity immediately, fifo_level_o=0, busy_o=0.
